bpsk_tx_scheduler: RTL and testbench
====================================

BPSK_TX_SCHEDULER -- requirements
Module: bpsk_tx_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PACKET_BYTES, 16: payload bytes per packet.
- PREAMBLE_BITS, 8: alternating 1,0,... bits sent before the payload.
- GUARD_BITS, 4: idle bit periods after each packet.
- CARRIER_PER_BIT, 1: carrier periods (phase_wrap pulses) per bit.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: the single clock; all logic is on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- phase_wrap, in, 1: one-cycle pulse when the carrier phase wraps to 0.
- req0, in, 1: requester 0 wants to transmit a packet.
- req1, in, 1: requester 1 wants to transmit a packet.
- data0, in, 8: requester 0 current payload byte.
- data1, in, 8: requester 1 current payload byte.
- byte_ack, out, 2: one-cycle pulse per requester when its byte is captured.
- grant, out, 2: one-hot owner of the modulator; 00 when idle.
- tx_enable, out, 1: carrier gate; high in PREAMBLE and PAYLOAD only.
- current_bit, out, 1: bit driven to the modulator.
- bit_strobe, out, 1: one-cycle pulse when current_bit takes a new value.
- busy, out, 1: high in every state except IDLE.
- underrun, out, 1: one-cycle pulse when a packet is aborted.

Function
REQ-003 The state machine SHALL have the states IDLE, PREAMBLE, PAYLOAD and GUARD.
REQ-004 A bit period SHALL end on the CARRIER_PER_BIT-th phase_wrap pulse counted since the period began.
- State, bit and shift changes SHALL take effect in the cycle after that pulse.
- bit_strobe SHALL pulse in that same cycle.
REQ-005 In IDLE, when any req is high on a phase_wrap pulse, the block SHALL arbitrate and set grant.
- The grant SHALL be round-robin: the requester not served last wins a tie.
- After reset, requester 0 SHALL be treated as served last, so requester 1 wins the first tie.
REQ-006 On grant, the block SHALL enter PREAMBLE with current_bit=1 and tx_enable=1, and pulse bit_strobe.
REQ-007 PREAMBLE SHALL last PREAMBLE_BITS bit periods with current_bit toggling each period, then enter PAYLOAD.
REQ-008 The block SHALL capture the granted requester's data byte into an 8-bit shift register, and pulse that requester's byte_ack for one cycle:
- at entry to PAYLOAD;
- after every 8th payload bit, except after the last byte.
REQ-009 Payload bits SHALL be sent MSB first, one bit per bit period.
REQ-010 The requester SHALL present the next byte no later than the cycle after byte_ack.
REQ-011 The byte counter SHALL count 0..PACKET_BYTES-1; after bit 0 of the last byte the block SHALL enter GUARD.
REQ-012 In GUARD:
- tx_enable=0, current_bit=0, and grant SHALL be held.
- After GUARD_BITS bit periods the block SHALL enter IDLE, clear grant, and record the served requester for REQ-005.
REQ-013 If the granted req is low at a byte capture point, the block SHALL:
- pulse underrun;
- not pulse byte_ack;
- enter GUARD immediately.
REQ-014 If the granted req drops at any other time during PAYLOAD, the block SHALL continue to the next byte capture point and then apply REQ-013.
REQ-015 The block SHALL ignore a req change on the ungranted requester until the return to IDLE.
REQ-016 If phase_wrap occurs in the same cycle as a state transition, the block SHALL count it toward the new bit period only if the transition did not consume it.
REQ-017 In IDLE the block SHALL hold current_bit=0, tx_enable=0 and grant=00.
REQ-018 The block SHALL ignore phase_wrap pulses in IDLE while no req is high.
REQ-019 The phase_wrap counter SHALL be wide enough for CARRIER_PER_BIT.
REQ-020 The bit counters SHALL be wide enough for max(PREAMBLE_BITS, GUARD_BITS, 8).
REQ-021 The byte counter SHALL be wide enough for PACKET_BYTES; no counter SHALL wrap silently.

Reset
REQ-022 While reset_n=0, the block SHALL asynchronously force:
- state=IDLE, grant=00, byte_ack=00;
- tx_enable, current_bit, bit_strobe, busy and underrun all 0;
- all counters and the shift register to 0;
- round-robin pointer to "requester 0 last served".
REQ-023 Reset asserted mid-packet SHALL abort the packet without an underrun pulse.
- After release, the block SHALL wait in IDLE for the next phase_wrap with a req high.
REQ-024 The block SHALL release reset synchronously with respect to its state updates, so the first transition occurs on the first qualifying clock edge after reset_n rises.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Scenario 1: req0=1, data0 sequence 0x48,0x65, PACKET_BYTES=2, defaults otherwise -> grant=01; current_bit sequence 1,0,1,0,1,0,1,0 then 0,1,0,0,1,0,0,0,0,1,1,0,0,1,0,1; then 4 periods with tx_enable=0; then IDLE.
- Scenario 2: req0=req1=1 from reset -> requester 1 served first; with both still high, requester 0 served next, so grant goes 10, then 00 for one cycle, then 01.
- Scenario 3: CARRIER_PER_BIT=4 -> exactly 4 phase_wrap pulses between successive bit_strobe pulses; current_bit is stable between them.
- Scenario 4: req0 dropped after the first byte ack of a 16-byte packet -> underrun pulses once at the second capture point; no second byte_ack; GUARD runs for 4 periods.
- Scenario 5: reset_n pulsed low during PAYLOAD byte 3 -> all outputs 0 and grant=00 within the same cycle; no underrun pulse; a new packet starts normally after release.
- Scenario 6: req1 asserted during a requester-0 packet -> grant stays 01 until IDLE, then goes to 10.

Source files
------------

// File: rtl/bpsk_tx_scheduler.sv
// BPSK transmit scheduler: arbitrates two requesters round-robin and serialises
// preamble, MSB-first payload bytes and guard periods against carrier phase wraps.
module bpsk_tx_scheduler #(
  parameter int unsigned PACKET_BYTES    = 16,
  parameter int unsigned PREAMBLE_BITS   = 8,
  parameter int unsigned GUARD_BITS      = 4,
  parameter int unsigned CARRIER_PER_BIT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       phase_wrap,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] byte_ack,
  output logic [1:0] grant,
  output logic       tx_enable,
  output logic       current_bit,
  output logic       bit_strobe,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned WrapW  = (CARRIER_PER_BIT > 1) ? $clog2(CARRIER_PER_BIT) : 1;
  localparam int unsigned BitMax = (PREAMBLE_BITS > GUARD_BITS) ?
                                   ((PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8) :
                                   ((GUARD_BITS > 8) ? GUARD_BITS : 8);
  localparam int unsigned BitW   = $clog2(BitMax);
  localparam int unsigned ByteW  = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;

  localparam logic [WrapW-1:0] WrapLast     = WrapW'(CARRIER_PER_BIT - 1);
  localparam logic [BitW-1:0]  PreambleLast = BitW'(PREAMBLE_BITS - 1);
  localparam logic [BitW-1:0]  GuardLast    = BitW'(GUARD_BITS - 1);
  localparam logic [BitW-1:0]  ByteBitLast  = BitW'(7);
  localparam logic [ByteW-1:0] ByteLast     = ByteW'(PACKET_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StPreamble, StPayload, StGuard} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;  // 1: requester 1 was served last
  logic [WrapW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             cur_bit_q, cur_bit_d;
  logic             strobe_q, strobe_d;
  logic [1:0]       ack_q, ack_d;
  logic             underrun_q, underrun_d;

  logic       period_end;
  logic       pick_req1;
  logic       granted_req;
  logic [7:0] granted_data;
  logic       capture;
  logic       enter_guard;

  assign period_end   = phase_wrap && (wrap_cnt_q == WrapLast);
  assign pick_req1    = req1 && (!req0 || !last_q);
  assign granted_req  = grant_q[1] ? req1 : req0;
  assign granted_data = grant_q[1] ? data1 : data0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      last_q     <= 1'b0;
      wrap_cnt_q <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= 8'h00;
      cur_bit_q  <= 1'b0;
      strobe_q   <= 1'b0;
      ack_q      <= 2'b00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wrap_cnt_q <= wrap_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      cur_bit_q  <= cur_bit_d;
      strobe_q   <= strobe_d;
      ack_q      <= ack_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    wrap_cnt_d  = wrap_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    cur_bit_d   = cur_bit_q;
    strobe_d    = 1'b0;
    ack_d       = 2'b00;
    underrun_d  = 1'b0;
    capture     = 1'b0;
    enter_guard = 1'b0;

    // Every transition is triggered by the wrap that ends a period, so that
    // wrap is always consumed and the new period starts counting from zero.
    if (state_q != StIdle && phase_wrap) begin
      wrap_cnt_d = period_end ? '0 : wrap_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (phase_wrap && (req0 || req1)) begin
          grant_d    = pick_req1 ? 2'b10 : 2'b01;
          state_d    = StPreamble;
          cur_bit_d  = 1'b1;
          strobe_d   = 1'b1;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          wrap_cnt_d = '0;
        end
      end
      StPreamble: begin
        if (period_end) begin
          strobe_d = 1'b1;
          if (bit_cnt_q == PreambleLast) begin
            capture = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            cur_bit_d = ~cur_bit_q;
          end
        end
      end
      StPayload: begin
        if (period_end) begin
          strobe_d = 1'b1;
          if (bit_cnt_q == ByteBitLast) begin
            if (byte_cnt_q == ByteLast) begin
              enter_guard = 1'b1;
            end else begin
              capture = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {shift_q[6:0], 1'b0};
            cur_bit_d = shift_q[6];
          end
        end
      end
      StGuard: begin
        if (period_end) begin
          if (bit_cnt_q == GuardLast) begin
            state_d   = StIdle;
            grant_d   = 2'b00;
            last_d    = grant_q[1];
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
    endcase

    // A capture point with the owner's req low aborts straight into guard.
    if (capture) begin
      if (granted_req) begin
        state_d    = StPayload;
        shift_d    = granted_data;
        cur_bit_d  = granted_data[7];
        ack_d      = grant_q;
        bit_cnt_d  = '0;
        byte_cnt_d = (state_q == StPayload) ? byte_cnt_q + 1'b1 : '0;
      end else begin
        underrun_d  = 1'b1;
        enter_guard = 1'b1;
      end
    end

    if (enter_guard) begin
      state_d   = StGuard;
      cur_bit_d = 1'b0;
      bit_cnt_d = '0;
    end
  end

  always_comb begin
    tx_enable   = (state_q == StPreamble) || (state_q == StPayload);
    busy        = (state_q != StIdle);
    grant       = grant_q;
    current_bit = cur_bit_q;
    bit_strobe  = strobe_q;
    byte_ack    = ack_q;
    underrun    = underrun_q;
  end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Directed bench for bpsk_tx_scheduler: a 2-byte/1-wrap instance (a) and a
// 16-byte/4-wrap instance (b) share stimulus; each scenario resets both first.
module tb_bpsk_tx_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pw;
  logic       req0, req1;
  logic [7:0] data0, data1;

  logic [1:0] ack_a, grant_a, ack_b, grant_b;
  logic       tx_a, bit_a, strobe_a, busy_a, und_a;
  logic       tx_b, bit_b, strobe_b, busy_b, und_b;

  int vec  = 0;
  int errs = 0;

  always #5 clock = ~clock;

  bpsk_tx_scheduler #(.PACKET_BYTES(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .phase_wrap(pw), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .byte_ack(ack_a), .grant(grant_a), .tx_enable(tx_a),
    .current_bit(bit_a), .bit_strobe(strobe_a), .busy(busy_a), .underrun(und_a)
  );

  bpsk_tx_scheduler #(.CARRIER_PER_BIT(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .phase_wrap(pw), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .byte_ack(ack_b), .grant(grant_b), .tx_enable(tx_b),
    .current_bit(bit_b), .bit_strobe(strobe_b), .busy(busy_b), .underrun(und_b)
  );

  task automatic do_reset();
    reset_n = 1'b0;
    pw = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int idle_bad = 0;
    do_reset();
    reset_n = 1'b0;
    #1;
    vec++;
    if ({ack_a, grant_a, tx_a, bit_a, strobe_a, busy_a, und_a} !== 9'd0) begin
      errs++;
      $display("FAIL reset_a: got %b want 0", {ack_a, grant_a, tx_a, bit_a, strobe_a, busy_a, und_a});
    end
    vec++;
    if ({ack_b, grant_b, tx_b, bit_b, strobe_b, busy_b, und_b} !== 9'd0) begin
      errs++;
      $display("FAIL reset_b: got %b want 0", {ack_b, grant_b, tx_b, bit_b, strobe_b, busy_b, und_b});
    end
    @(negedge clock);
    reset_n = 1'b1;
    pw = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (busy_a || busy_b || grant_a != 2'b00 || tx_a || bit_a) idle_bad++;
    end
    pw = 1'b0;
    vec++;
    if (idle_bad !== 0) begin
      errs++;
      $display("FAIL idle_no_req: got %0d busy cycles want 0", idle_bad);
    end
  endtask

  task automatic test_packet();
    logic [23:0] want = 24'b1010_1010_0100_1000_0110_0101;
    logic [23:0] got = '0;
    int nbits = 0, acks = 0, guard = 0, guard_bad = 0, grant_bad = 0;
    bit started = 0, done = 0;
    do_reset();
    data0 = 8'h48; req0 = 1'b1; pw = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (busy_a) begin
        started = 1;
        if (grant_a !== 2'b01) grant_bad++;
      end
      if (strobe_a && tx_a) begin
        got = {got[22:0], bit_a};
        nbits++;
      end
      if (ack_a[0]) begin
        acks++;
        data0 = 8'h65;
      end
      if (busy_a && !tx_a) begin
        guard++;
        if (bit_a !== 1'b0) guard_bad++;
      end
      if (started && !busy_a) begin
        done = 1;
        req0 = 1'b0;
      end
    end
    vec++;
    if (!done) begin errs++; $display("FAIL pkt_timeout: got busy want idle"); end
    vec++;
    if (nbits !== 24 || got !== want) begin
      errs++;
      $display("FAIL pkt_bits: got %0d bits %b want 24 bits %b", nbits, got, want);
    end
    vec++;
    if (acks !== 2) begin errs++; $display("FAIL pkt_acks: got %0d want 2", acks); end
    vec++;
    if (guard !== 4) begin errs++; $display("FAIL pkt_guard: got %0d want 4", guard); end
    vec++;
    if (guard_bad !== 0 || grant_bad !== 0) begin
      errs++;
      $display("FAIL pkt_grant_guardbit: got %0d/%0d bad cycles want 0/0", grant_bad, guard_bad);
    end
    vec++;
    if (grant_a !== 2'b00) begin errs++; $display("FAIL pkt_idle_grant: got %b want 00", grant_a); end
  endtask

  task automatic test_round_robin();
    int stage = 0, gap = 0;
    logic [1:0] first = 2'b00, second = 2'b00;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; pw = 1'b1;
    for (int c = 0; c < 120 && stage != 3; c++) begin
      @(negedge clock);
      case (stage)
        0: if (grant_a != 2'b00) begin first = grant_a; stage = 1; end
        1: if (grant_a == 2'b00) begin gap = 1; stage = 2; end
        2: if (grant_a == 2'b00) gap++; else begin second = grant_a; stage = 3; end
        default: ;
      endcase
    end
    req0 = 1'b0; req1 = 1'b0;
    vec++;
    if (first !== 2'b10) begin errs++; $display("FAIL rr_first: got %b want 10", first); end
    vec++;
    if (gap !== 1) begin errs++; $display("FAIL rr_gap: got %0d want 1", gap); end
    vec++;
    if (second !== 2'b01) begin errs++; $display("FAIL rr_second: got %b want 01", second); end
  endtask

  task automatic test_carrier();
    int cnt = 0, intervals = 0, unstable = 0;
    bit first = 1;
    logic held = 1'b0, want_bit = 1'b1;
    do_reset();
    data0 = 8'hA5; req0 = 1'b1;
    for (int c = 0; c < 200 && intervals < 6; c++) begin
      @(negedge clock);
      if (strobe_b) begin
        if (!first) begin
          intervals++;
          vec++;
          if (cnt !== 4) begin errs++; $display("FAIL carrier_wraps: got %0d want 4", cnt); end
          vec++;
          if (unstable !== 0) begin
            errs++;
            $display("FAIL carrier_stable: got %0d changes want 0", unstable);
          end
        end
        vec++;
        if (bit_b !== want_bit) begin
          errs++;
          $display("FAIL carrier_preamble_bit: got %b want %b", bit_b, want_bit);
        end
        want_bit = ~want_bit;
        first = 0; cnt = 0; unstable = 0; held = bit_b;
      end else if (!first && bit_b !== held) begin
        unstable++;
      end
      pw = (c % 3 == 0);
      if (pw) cnt++;
    end
    pw = 1'b0;
    vec++;
    if (intervals !== 6) begin errs++; $display("FAIL carrier_timeout: got %0d want 6", intervals); end
  endtask

  task automatic test_underrun();
    int acks = 0, und = 0, ack_c = -1, und_c = -1, guard = 0;
    logic [1:0] und_grant = 2'b00;
    bit started = 0, done = 0;
    do_reset();
    data0 = 8'h3C; req0 = 1'b1; pw = 1'b1;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clock);
      if (busy_b) started = 1;
      if (ack_b[0]) begin acks++; ack_c = c; req0 = 1'b0; end
      if (und_b) begin und++; und_c = c; und_grant = grant_b; end
      if (busy_b && !tx_b) guard++;
      if (started && !busy_b) done = 1;
    end
    vec++;
    if (!done) begin errs++; $display("FAIL und_timeout: got busy want idle"); end
    vec++;
    if (acks !== 1) begin errs++; $display("FAIL und_acks: got %0d want 1", acks); end
    vec++;
    if (und !== 1) begin errs++; $display("FAIL und_count: got %0d want 1", und); end
    vec++;
    if (und_c - ack_c !== 32) begin
      errs++;
      $display("FAIL und_position: got %0d cycles want 32", und_c - ack_c);
    end
    vec++;
    if (guard !== 16) begin errs++; $display("FAIL und_guard: got %0d cycles want 16", guard); end
    vec++;
    if (und_grant !== 2'b01) begin errs++; $display("FAIL und_grant: got %b want 01", und_grant); end
  endtask

  task automatic test_reset_mid();
    int acks = 0, und = 0, idle_bad = 0;
    bit restarted = 0;
    do_reset();
    data0 = 8'h5A; req0 = 1'b1; pw = 1'b1;
    for (int c = 0; c < 1000 && acks < 3; c++) begin
      @(negedge clock);
      if (ack_b[0]) acks++;
      if (und_b) und++;
    end
    repeat (6) begin
      @(negedge clock);
      if (und_b) und++;
    end
    vec++;
    if (acks !== 3 || busy_b !== 1'b1) begin
      errs++;
      $display("FAIL mid_setup: got %0d acks busy %b want 3 acks busy 1", acks, busy_b);
    end
    reset_n = 1'b0;
    #1;
    vec++;
    if ({ack_b, grant_b, tx_b, bit_b, strobe_b, busy_b, und_b} !== 9'd0) begin
      errs++;
      $display("FAIL mid_async_clear: got %b want 0", {ack_b, grant_b, tx_b, bit_b, strobe_b, busy_b, und_b});
    end
    @(negedge clock);
    req0 = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (und_b) und++;
      if (busy_b) idle_bad++;
    end
    vec++;
    if (idle_bad !== 0) begin errs++; $display("FAIL mid_wait_idle: got %0d busy want 0", idle_bad); end
    req0 = 1'b1;
    for (int c = 0; c < 10 && !restarted; c++) begin
      @(negedge clock);
      if (und_b) und++;
      if (busy_b) begin
        restarted = 1;
        vec++;
        if ({grant_b, tx_b, bit_b, strobe_b} !== 5'b01111) begin
          errs++;
          $display("FAIL mid_restart: got %b want 01111", {grant_b, tx_b, bit_b, strobe_b});
        end
      end
    end
    vec++;
    if (!restarted) begin errs++; $display("FAIL mid_restart_timeout: got idle want busy"); end
    vec++;
    if (und !== 0) begin errs++; $display("FAIL mid_no_underrun: got %0d want 0", und); end
  endtask

  task automatic test_ignore_other();
    int stage = 0, bad = 0;
    logic [1:0] first = 2'b00, second = 2'b00;
    do_reset();
    req0 = 1'b1; pw = 1'b1;
    for (int c = 0; c < 120 && stage != 3; c++) begin
      @(negedge clock);
      case (stage)
        0: if (grant_a != 2'b00) begin first = grant_a; req1 = 1'b1; stage = 1; end
        1: begin
          if (grant_a == 2'b00) stage = 2;
          else if (grant_a !== 2'b01) bad++;
        end
        2: if (grant_a != 2'b00) begin second = grant_a; stage = 3; end
        default: ;
      endcase
    end
    req0 = 1'b0; req1 = 1'b0;
    vec++;
    if (first !== 2'b01) begin errs++; $display("FAIL other_first: got %b want 01", first); end
    vec++;
    if (bad !== 0) begin errs++; $display("FAIL other_held: got %0d bad cycles want 0", bad); end
    vec++;
    if (second !== 2'b10) begin errs++; $display("FAIL other_next: got %b want 10", second); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_round_robin();
    test_carrier();
    test_underrun();
    test_reset_mid();
    test_ignore_other();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
